input_conditioner: RTL and testbench



---
 rtl/input_conditioner.sv | 114 +++++++++++
 tb/tb_input_conditioner.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// input_conditioner: N-channel synchronizer + debouncer + edge/long-press pulser
// for asynchronous, bouncing board inputs. Each channel is an independent lane.

module input_conditioner_lane #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 0,
    parameter bit POLARITY        = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic hold
);
    localparam int                 CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   sample;
    logic [CNT_W-1:0]       cnt;

    // synchronizer chain; idles at the pin's inactive level so reset exit is quiet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= {SYNC_STAGES{POLARITY}};
        else        sync <= {sync[SYNC_STAGES-2:0], raw};
    end

    // normalise to active-high
    assign sample = sync[SYNC_STAGES-1] ^ POLARITY;

    // accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (sample == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sample;
                rise  <= sample;
                fall  <= ~sample;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    generate
        if (HOLD_CYCLES > 0) begin : g_hold
            localparam int              HC_W   = $clog2(HOLD_CYCLES + 1);
            localparam logic [HC_W-1:0] HC_MAX = HC_W'(HOLD_CYCLES);
            localparam logic [HC_W-1:0] HC_PRE = HC_W'(HOLD_CYCLES - 1);
            logic [HC_W-1:0] hc;

            // count asserted cycles; saturate so each press yields one hold pulse
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hc   <= '0;
                    hold <= 1'b0;
                end else begin
                    hold <= level && (hc == HC_PRE);
                    if (!level)             hc <= '0;
                    else if (hc != HC_MAX)  hc <= hc + HC_W'(1);
                end
            end
        end else begin : g_no_hold
            assign hold = 1'b0;
        end
    endgenerate
endmodule

module input_conditioner #(
    parameter int                 width_p           = 3,
    parameter int                 sync_stages_p     = 2,
    parameter int                 debounce_cycles_p = 4,
    parameter int                 hold_cycles_p     = 0,
    parameter logic [width_p-1:0] polarity_p        = '0
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] raw_i,
    output logic [width_p-1:0] level_o,
    output logic [width_p-1:0] rise_o,
    output logic [width_p-1:0] fall_o,
    output logic [width_p-1:0] hold_o
);
    generate
        for (genvar i = 0; i < width_p; i++) begin : g_lane
            input_conditioner_lane #(
                .SYNC_STAGES    (sync_stages_p),
                .DEBOUNCE_CYCLES(debounce_cycles_p),
                .HOLD_CYCLES    (hold_cycles_p),
                .POLARITY       (polarity_p[i])
            ) u_lane (
                .clk  (clk_i),
                .rst_n(reset_n_i),
                .raw  (raw_i[i]),
                .level(level_o[i]),
                .rise (rise_o[i]),
                .fall (fall_o[i]),
                .hold (hold_o[i])
            );
        end
    endgenerate
endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed scenarios plus random bouncing inputs,
// every cycle compared against a window-based behavioural model.

module tb_input_conditioner;
    localparam int             W    = 3;
    localparam int             SYNC = 2;
    localparam int             DB   = 4;
    localparam int             HOLD = 10;
    localparam logic [W-1:0]   POL  = 3'b001;
    localparam logic [W-1:0]   IDLE = POL;

    logic         clk_i     = 1'b0;
    logic         reset_n_i = 1'b0;
    logic [W-1:0] raw_i     = IDLE;
    logic [W-1:0] level_o, rise_o, fall_o, hold_o;

    input_conditioner #(
        .width_p          (W),
        .sync_stages_p    (SYNC),
        .debounce_cycles_p(DB),
        .hold_cycles_p    (HOLD),
        .polarity_p       (POL)
    ) dut (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .raw_i    (raw_i),
        .level_o  (level_o),
        .rise_o   (rise_o),
        .fall_o   (fall_o),
        .hold_o   (hold_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_bad = 0;

    // model state: samples in flight through the synchronizer, recent
    // debouncer samples, and the edge on which each channel last rose
    logic [W-1:0] pipe_q[$];
    logic [W-1:0] s_hist[$];
    logic [W-1:0] m_level, m_rise, m_fall, m_hold;
    int           edge_n;
    int           rise_at[W];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    task automatic model_reset();
        pipe_q.delete();
        for (int k = 0; k < SYNC; k++) pipe_q.push_back('0);
        s_hist.delete();
        m_level = '0; m_rise = '0; m_fall = '0; m_hold = '0;
        edge_n  = 0;
        for (int i = 0; i < W; i++) rise_at[i] = -1000000;
    endtask

    // one rising edge: a level flips once the last DB samples all disagree with it;
    // a hold pulse fires HOLD edges after a rise if the level stayed up until then
    task automatic model_edge(input logic [W-1:0] r);
        logic [W-1:0] s, nl;
        bit all_diff;
        edge_n++;
        s = pipe_q.pop_front();
        pipe_q.push_back(r ^ POL);
        s_hist.push_back(s);
        if (s_hist.size() > DB) s_hist.delete(0);
        nl = m_level;
        for (int i = 0; i < W; i++) begin
            m_hold[i] = m_level[i] && ((edge_n - rise_at[i]) == HOLD);
            if (s_hist.size() == DB) begin
                all_diff = 1'b1;
                for (int k = 0; k < DB; k++)
                    if (s_hist[k][i] == m_level[i]) all_diff = 1'b0;
                if (all_diff) nl[i] = ~m_level[i];
            end
        end
        m_rise = nl & ~m_level;
        m_fall = ~nl & m_level;
        for (int i = 0; i < W; i++) if (m_rise[i]) rise_at[i] = edge_n;
        m_level = nl;
    endtask

    // drive at negedge, advance one edge, compare at the following negedge
    task automatic step(input logic [W-1:0] r);
        raw_i = r;
        @(posedge clk_i);
        model_edge(r);
        @(negedge clk_i);
        check("level", level_o, m_level);
        check("rise",  rise_o,  m_rise);
        check("fall",  fall_o,  m_fall);
        check("hold",  hold_o,  m_hold);
    endtask

    task automatic apply_reset(input logic [W-1:0] r, input int cycles);
        reset_n_i = 1'b0;
        raw_i     = r;
        #1;
        check("rst_now", {level_o, rise_o, fall_o, hold_o}, '0);
        model_reset();
        repeat (cycles) begin
            @(posedge clk_i);
            @(negedge clk_i);
            check("rst_hold", {level_o, rise_o, fall_o, hold_o}, '0);
        end
        reset_n_i = 1'b1;
    endtask

    int           cap_e, rise_e, hold_e, fall_e, n_rise, n_fall, n_hold, n_hold2, hi_cnt;
    logic [W-1:0] r;
    int           run[W];
    bit           seen;

    initial begin
        model_reset();
        @(negedge clk_i);

        // reset with idle pins, then quiet idle
        apply_reset(IDLE, 4);
        for (int c = 0; c < 20; c++) begin
            step(IDLE);
            check("idle_quiet", {level_o, rise_o, fall_o, hold_o}, '0);
        end

        // clean press on ch1: rise 5 edges after capture, hold 10 after rise, once
        rise_e = -1; hold_e = -1; n_hold = 0; n_rise = 0;
        step(3'b011);
        cap_e = edge_n;
        for (int c = 0; c < 30; c++) begin
            step(3'b011);
            if (rise_o[1]) begin n_rise++; if (rise_e < 0) rise_e = edge_n; end
            if (hold_o[1]) begin n_hold++; if (hold_e < 0) hold_e = edge_n; end
        end
        check("press_lat",  rise_e - cap_e, 5);
        check("press_nrise", n_rise, 1);
        check("press_hold", hold_e - rise_e, 10);
        check("press_nhold", n_hold, 1);
        for (int c = 0; c < 12; c++) step(IDLE);

        // bounce on ch2: highs of 1,2,3 separated by single lows, then stable
        n_rise = 0;
        step(3'b101); step(IDLE);
        step(3'b101); step(3'b101); step(IDLE);
        step(3'b101); step(3'b101); step(3'b101); step(IDLE);
        check("bounce_quiet", n_rise + rise_o[2] + fall_o[2], 0);
        rise_e = -1;
        step(3'b101);
        cap_e = edge_n;
        if (rise_o[2]) n_rise++;
        for (int c = 0; c < 14; c++) begin
            step(3'b101);
            if (rise_o[2]) begin n_rise++; if (rise_e < 0) rise_e = edge_n; end
        end
        check("bounce_nrise", n_rise, 1);
        check("bounce_lat", rise_e - cap_e, 5);
        for (int c = 0; c < 12; c++) step(IDLE);

        // active-low ch0: pin low for 8 cycles
        n_rise = 0; n_fall = 0; n_hold = 0; seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step(3'b000);
            n_rise += rise_o[0]; n_fall += fall_o[0]; n_hold += hold_o[0];
            if (level_o[0]) seen = 1'b1;
        end
        for (int c = 0; c < 14; c++) begin
            step(IDLE);
            n_rise += rise_o[0]; n_fall += fall_o[0]; n_hold += hold_o[0];
            if (level_o[0]) seen = 1'b1;
        end
        check("al_level", seen, 1);
        check("al_nrise", n_rise, 1);
        check("al_nfall", n_fall, 1);
        check("al_nhold", n_hold, 0);

        // simultaneous press ch1+ch2; ch2 released as soon as it rises
        r = 3'b111; rise_e = -1; hold_e = -1; n_fall = 0; n_hold2 = 0;
        for (int c = 0; c < 30; c++) begin
            step(r);
            if (rise_o != '0 && rise_e < 0) begin
                check("sim_rise", rise_o, 3'b110);
                rise_e = edge_n;
                r = 3'b011;
            end
            n_fall  += fall_o[2];
            n_hold2 += hold_o[2];
            if (hold_o[1] && hold_e < 0) hold_e = edge_n;
        end
        check("sim_fall2", n_fall, 1);
        check("sim_hold2", n_hold2, 0);
        check("sim_hold1", hold_e - rise_e, 10);
        for (int c = 0; c < 12; c++) step(IDLE);

        // release landing exactly on the hold edge still pulses hold
        r = 3'b011; rise_e = -1; hold_e = -1; fall_e = -1; hi_cnt = 0; n_hold = 0;
        for (int c = 0; c < 30; c++) begin
            step(r);
            if (rise_o[1] && rise_e < 0) rise_e = edge_n;
            if (level_o[1]) hi_cnt++;
            if (hi_cnt == 5) r = IDLE;
            if (hold_o[1]) begin n_hold++; hold_e = edge_n; end
            if (fall_o[1] && fall_e < 0) fall_e = edge_n;
        end
        check("edge_hold_n", n_hold, 1);
        check("edge_hold_at", hold_e - fall_e, 0);
        check("edge_fall_at", fall_e - rise_e, 10);

        // reset mid-press when hc reaches 7, then re-press straight out of reset
        for (int c = 0; c < 40; c++) begin
            if (m_level[1] && (edge_n - rise_at[1]) == 7) break;
            step(3'b011);
        end
        check("mid_hc7", edge_n - rise_at[1], 7);
        apply_reset(3'b011, 3);
        rise_e = -1; hold_e = -1;
        for (int c = 0; c < 25; c++) begin
            step(3'b011);
            if (rise_o[1] && rise_e < 0) rise_e = edge_n;
            if (hold_o[1] && hold_e < 0) hold_e = edge_n;
        end
        check("post_rst_lat", rise_e - 1, 5);
        check("post_rst_hold", hold_e - rise_e, 10);
        for (int c = 0; c < 12; c++) step(IDLE);

        // every-cycle toggling never moves the level
        r = IDLE;
        for (int c = 0; c < 40; c++) begin
            r = r ^ 3'b111;
            step(r);
            check("toggle_lvl", level_o, '0);
        end
        for (int c = 0; c < 8; c++) step(IDLE);

        // random run lengths per channel, mixing glitches and real presses
        r = IDLE;
        for (int i = 0; i < W; i++) run[i] = $urandom_range(1, 12);
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < W; i++) begin
                if (run[i] == 0) begin
                    r[i]   = ~r[i];
                    run[i] = $urandom_range(1, 16);
                end else begin
                    run[i]--;
                end
            end
            step(r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
